regfile_write_port: RTL and testbench

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_write_port_if.sv | 23 ++
 rtl/regfile_write_port.sv | 83 ++++++++
 tb/tb_regfile_write_port.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/regfile_write_port_if.sv
// Writeback request, wipe request and register-file write-side signals
// shared between the pipeline/bench (master) and regfile_write_port (slave).
interface regfile_write_port_if;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wipe;
    logic [15:0] C;
    logic [3:0]  Caddr;
    logic        load;
    logic        stall;
    logic        sweep_done;

    modport master (
        output wb_valid, wb_addr, wb_data, wipe,
        input  C, Caddr, load, stall, sweep_done
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, wipe,
        output C, Caddr, load, stall, sweep_done
    );
endinterface

// File: rtl/regfile_write_port.sv
// Register-file write port: forwards WB-stage writes (never to r0) and runs
// a zeroing sweep of r1..r15 on wipe and after every reset.
//   state | meaning
//   IDLE  | forward writebacks, accept wipe
//   SWEEP | write zero to r[ptr], ptr counts 1..15, writebacks stalled
module regfile_write_port (
    input  logic                 clk,
    input  logic                 clr,
    regfile_write_port_if.slave  wp
);
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] c_q, c_d;
    logic [3:0]  caddr_q, caddr_d;
    logic        load_q, load_d;
    logic        stall_q, stall_d;
    logic        sweep_done_q, sweep_done_d;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        c_d          = c_q;
        caddr_d      = caddr_q;
        load_d       = 1'b0;
        sweep_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A writeback arriving with wipe is still taken; the sweep follows it.
                if (wp.wb_valid && (wp.wb_addr != 4'd0)) begin
                    load_d  = 1'b1;
                    c_d     = wp.wb_data;
                    caddr_d = wp.wb_addr;
                end
                if (wp.wipe) begin
                    state_d = SWEEP;
                    ptr_d   = 4'd1;
                end
            end
            SWEEP: begin
                load_d  = 1'b1;
                caddr_d = ptr_q;
                c_d     = 16'h0000;
                if (ptr_q == 4'd15) begin
                    state_d      = IDLE;
                    sweep_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        stall_d = (state_d == SWEEP);
    end

    // Reset lands in SWEEP so the register file is cleared after every clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= SWEEP;
            ptr_q        <= 4'd1;
            c_q          <= 16'h0000;
            caddr_q      <= 4'd0;
            load_q       <= 1'b0;
            stall_q      <= 1'b1;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            c_q          <= c_d;
            caddr_q      <= caddr_d;
            load_q       <= load_d;
            stall_q      <= stall_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign wp.C          = c_q;
    assign wp.Caddr      = caddr_q;
    assign wp.load       = load_q;
    assign wp.stall      = stall_q;
    assign wp.sweep_done = sweep_done_q;
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: expected writes are queued as stimulus
// is driven and popped whenever the DUT raises load.
module tb_regfile_write_port;
    logic clk;
    logic clr;

    regfile_write_port_if wp ();

    regfile_write_port dut (
        .clk (clk),
        .clr (clr),
        .wp  (wp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file attached to the write port.
    logic [15:0] rf_a [16];
    always @(posedge clk) if (wp.load) rf_a[wp.Caddr] <= wp.C;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        done;
        logic        stall;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag);
        exp_t e;
        chk({tag, "_load"}, 32'(wp.load), 32'd1);
        chk({tag, "_queued"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_caddr"}, 32'(wp.Caddr), 32'(e.addr));
            chk({tag, "_c"}, 32'(wp.C), 32'(e.data));
            chk({tag, "_done"}, 32'(wp.sweep_done), 32'(e.done));
            chk({tag, "_stall"}, 32'(wp.stall), 32'(e.stall));
        end
    endtask

    task automatic run_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            expect_write(tag);
        end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input logic exp_stall);
        chk({tag, "_load"}, 32'(wp.load), 32'd0);
        chk({tag, "_done"}, 32'(wp.sweep_done), 32'd0);
        chk({tag, "_stall"}, 32'(wp.stall), 32'(exp_stall));
    endtask

    task automatic push_sweep();
        for (int i = 1; i <= 15; i++)
            q.push_back('{addr: 4'(i), data: 16'h0000, done: (i == 15), stall: (i != 15)});
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [15:0] d, input logic s);
        q.push_back('{addr: a, data: d, done: 1'b0, stall: s});
    endtask

    initial begin
        clr         = 1'b1;
        wp.wb_valid = 1'b0;
        wp.wb_addr  = 4'd0;
        wp.wb_data  = 16'h0000;
        wp.wipe     = 1'b0;

        // Reset held two cycles, then the automatic clearing sweep.
        for (int k = 0; k < 2; k++) begin
            step();
            expect_quiet("rst", 1'b1);
            chk("rst_caddr", 32'(wp.Caddr), 32'd0);
            chk("rst_c", 32'(wp.C), 32'd0);
        end
        clr = 1'b0;
        push_sweep();
        run_cycles("rst_sweep", 15);
        step();
        expect_quiet("post_rst", 1'b0);

        // Single writeback, then read back through the register file.
        wp.wb_valid = 1'b1; wp.wb_addr = 4'h7; wp.wb_data = 16'hBEEF;
        push_wr(4'h7, 16'hBEEF, 1'b0);
        run_cycles("wb", 1);
        wp.wb_valid = 1'b0;
        step();
        expect_quiet("wb_idle", 1'b0);
        chk("wb_hold_caddr", 32'(wp.Caddr), 32'h7);
        chk("wb_hold_c", 32'(wp.C), 32'hBEEF);
        chk("wb_rf7", 32'(rf_a[7]), 32'hBEEF);

        // Writes to r0 are dropped.
        wp.wb_valid = 1'b1; wp.wb_addr = 4'h0; wp.wb_data = 16'h1234;
        step();
        wp.wb_valid = 1'b0;
        expect_quiet("r0", 1'b0);
        chk("r0_hold_caddr", 32'(wp.Caddr), 32'h7);
        chk("r0_hold_c", 32'(wp.C), 32'hBEEF);

        // Back-to-back writebacks.
        for (int i = 1; i <= 4; i++) begin
            wp.wb_valid = 1'b1; wp.wb_addr = 4'(i); wp.wb_data = 16'hA000 + 16'(i * 17);
            push_wr(4'(i), 16'hA000 + 16'(i * 17), 1'b0);
            step();
            expect_write("b2b");
        end
        wp.wb_valid = 1'b0;
        step();
        expect_quiet("b2b_end", 1'b0);

        // wipe and writeback together; requests during the sweep are ignored.
        wp.wipe = 1'b1; wp.wb_valid = 1'b1; wp.wb_addr = 4'h3; wp.wb_data = 16'h00AA;
        push_wr(4'h3, 16'h00AA, 1'b1);
        run_cycles("simul_wb", 1);
        wp.wb_addr = 4'h5; wp.wb_data = 16'h5555;
        push_sweep();
        run_cycles("simul_sweep", 15);
        wp.wipe = 1'b0; wp.wb_valid = 1'b0;
        step();
        expect_quiet("simul_end", 1'b0);
        for (int i = 1; i <= 15; i++)
            chk($sformatf("rf_zero_%0d", i), 32'(rf_a[i]), 32'd0);

        // Sweep aborted by clr on its 6th cycle restarts from r1.
        wp.wipe = 1'b1;
        step();
        wp.wipe = 1'b0;
        expect_quiet("abort_start", 1'b1);
        for (int i = 1; i <= 5; i++) push_wr(4'(i), 16'h0000, 1'b1);
        run_cycles("abort_part", 5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        expect_quiet("abort_clr", 1'b1);
        push_sweep();
        run_cycles("abort_restart", 15);
        step();
        expect_quiet("abort_end", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
